// File: rtl/load_align_unit.sv
// Load align unit: issues one or two aligned memory beats per load, merges, right-justifies and extends.
// Latency: accept->result 2 cycles for one zero-wait beat, +1 per second beat, +1 per wait cycle; faults 1 cycle.
// Backpressure: ld_req_ready_out is high only in IDLE; dm_req_out/dm_addr_out hold until dm_ack_in.
//
// Ports:
//   clk_in, rst_in                 clock (rising edge), synchronous active-high reset
//   ld_req_valid_in/ready_out      load request handshake; ld_addr/size/unsigned/rd sampled on accept
//   dm_req_out, dm_addr_out        memory read request with aligned beat address (0 when idle)
//   dm_ack_in, dm_rdata_in         memory accept; read data valid in the same cycle as the ack
//   lu_valid_out                   one-cycle result pulse
//   lu_data_out/rd_out/fault_out   registered result, held until the next result
//
// Build option: define MISALIGNED_SPLIT_EN to split word-crossing loads into two beats.
// Without it a crossing load faults immediately and the second-beat logic is not built.

module load_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ld_req_valid_in,
  output logic              ld_req_ready_out,
  input  logic [ADDR_W-1:0] ld_addr_in,
  input  logic [1:0]        ld_size_in,
  input  logic              ld_unsigned_in,
  input  logic [4:0]        ld_rd_in,
  output logic              dm_req_out,
  output logic [ADDR_W-1:0] dm_addr_out,
  input  logic              dm_ack_in,
  input  logic [XLEN-1:0]   dm_rdata_in,
  output logic              lu_valid_out,
  output logic [XLEN-1:0]   lu_data_out,
  output logic [4:0]        lu_rd_out,
  output logic              lu_fault_out
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);
  // Wide enough to hold off + nbytes without overflow (max 2*BYTES-1).
  localparam int NB_W  = OFS_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
`ifdef MISALIGNED_SPLIT_EN
  logic [XLEN-1:0]   lo_q, lo_d;
`endif
  logic [XLEN-1:0]   lu_data_q, lu_data_d;
  logic [4:0]        lu_rd_q, lu_rd_d;
  logic              lu_fault_q, lu_fault_d;

  logic [ADDR_W-1:0] beat0_addr;
  logic [OFS_W-1:0]  off_q;
  logic              cross_q;
  logic              req_illegal;
  logic              req_fault;

  // True when the access spills past the end of its aligned word.
  function automatic logic crosses(input logic [OFS_W-1:0] off, input logic [1:0] size);
    logic [NB_W-1:0] end_byte;
    end_byte = {2'b00, off} + (NB_W'(1) << size);
    return end_byte > NB_W'(BYTES);
  endfunction

  // Shift the {hi,lo} pair down by the byte offset, keep nbytes bytes and
  // fill the rest with zeros or the sign bit. For nbytes == BYTES the keep
  // mask is all ones, so the unsigned flag has no effect there.
  function automatic logic [XLEN-1:0] align_extend(
    input logic [2*XLEN-1:0] pair,
    input logic [OFS_W-1:0]  off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] keep;
    logic [6:0]      nbits;
    logic            sign;
    raw   = XLEN'(pair >> {off, 3'b000});
    nbits = 7'd8 << size;
    keep  = ~({XLEN{1'b1}} << nbits);
    case (size)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase
    sign = sign & ~uns;
    return (raw & keep) | (~keep & {XLEN{sign}});
  endfunction

  assign off_q      = addr_q[OFS_W-1:0];
  assign cross_q    = crosses(off_q, size_q);
  assign beat0_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  // A dword request only exists on 64-bit builds.
  assign req_illegal = (XLEN == 32) && (ld_size_in == 2'b11);

`ifdef MISALIGNED_SPLIT_EN
  assign req_fault = req_illegal;
`else
  assign req_fault = req_illegal || crosses(ld_addr_in[OFS_W-1:0], ld_size_in);
`endif

  // Next-state and result computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
`ifdef MISALIGNED_SPLIT_EN
    lo_d       = lo_q;
`endif
    lu_data_d  = lu_data_q;
    lu_rd_d    = lu_rd_q;
    lu_fault_d = lu_fault_q;

    case (state_q)
      IDLE: begin
        if (ld_req_valid_in) begin
          addr_d = ld_addr_in;
          size_d = ld_size_in;
          uns_d  = ld_unsigned_in;
          rd_d   = ld_rd_in;
          if (req_fault) begin
            // Faults skip memory entirely; the result is ready next cycle.
            state_d    = DONE;
            lu_data_d  = '0;
            lu_rd_d    = ld_rd_in;
            lu_fault_d = 1'b1;
          end else begin
            state_d = BEAT0;
          end
        end
      end

      BEAT0: begin
        if (dm_ack_in) begin
`ifdef MISALIGNED_SPLIT_EN
          if (cross_q) begin
            lo_d    = dm_rdata_in;
            state_d = BEAT1;
          end else
`endif
          begin
            // Single-beat load: merge straight from the returning data.
            state_d    = DONE;
            lu_data_d  = align_extend({{XLEN{1'b0}}, dm_rdata_in}, off_q, size_q, uns_q);
            lu_rd_d    = rd_q;
            lu_fault_d = 1'b0;
          end
        end
      end

`ifdef MISALIGNED_SPLIT_EN
      BEAT1: begin
        // The high beat is merged on arrival, so it lands directly in the
        // result register rather than a separate buffer.
        if (dm_ack_in) begin
          state_d    = DONE;
          lu_data_d  = align_extend({dm_rdata_in, lo_q}, off_q, size_q, uns_q);
          lu_rd_d    = rd_q;
          lu_fault_d = 1'b0;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat address: zero whenever no request is outstanding.
  always_comb begin
    dm_addr_out = '0;
    case (state_q)
      BEAT0:   dm_addr_out = beat0_addr;
`ifdef MISALIGNED_SPLIT_EN
      BEAT1:   dm_addr_out = beat0_addr + ADDR_W'(BYTES);
`endif
      default: dm_addr_out = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
`ifdef MISALIGNED_SPLIT_EN
      lo_q       <= '0;
`endif
      lu_data_q  <= '0;
      lu_rd_q    <= '0;
      lu_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
`ifdef MISALIGNED_SPLIT_EN
      lo_q       <= lo_d;
`endif
      lu_data_q  <= lu_data_d;
      lu_rd_q    <= lu_rd_d;
      lu_fault_q <= lu_fault_d;
    end
  end

  assign ld_req_ready_out = (state_q == IDLE);
  assign dm_req_out       = (state_q == BEAT0) || (state_q == BEAT1);
  assign lu_valid_out     = (state_q == DONE);
  assign lu_data_out      = lu_data_q;
  assign lu_rd_out        = lu_rd_q;
  assign lu_fault_out     = lu_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 32-bit instance
  logic        v32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [1:0]  sz32 = '0;
  logic        un32 = 1'b0;
  logic [4:0]  rd32 = '0;
  logic        ack32 = 1'b0;
  logic [31:0] rdat32 = '0;
  logic        rdy32, req32, val32, flt32;
  logic [31:0] dma32, dat32;
  logic [4:0]  lrd32;

  // 64-bit instance
  logic        v64 = 1'b0;
  logic [31:0] a64 = '0;
  logic [1:0]  sz64 = '0;
  logic        un64 = 1'b0;
  logic [4:0]  rd64 = '0;
  logic        ack64 = 1'b0;
  logic [63:0] rdat64 = '0;
  logic        rdy64, req64, val64, flt64;
  logic [31:0] dma64;
  logic [63:0] dat64;
  logic [4:0]  lrd64;

  load_align_unit #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk_in(clk), .rst_in(rst),
    .ld_req_valid_in(v32), .ld_req_ready_out(rdy32),
    .ld_addr_in(a32), .ld_size_in(sz32), .ld_unsigned_in(un32), .ld_rd_in(rd32),
    .dm_req_out(req32), .dm_addr_out(dma32), .dm_ack_in(ack32), .dm_rdata_in(rdat32),
    .lu_valid_out(val32), .lu_data_out(dat32), .lu_rd_out(lrd32), .lu_fault_out(flt32)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk_in(clk), .rst_in(rst),
    .ld_req_valid_in(v64), .ld_req_ready_out(rdy64),
    .ld_addr_in(a64), .ld_size_in(sz64), .ld_unsigned_in(un64), .ld_rd_in(rd64),
    .dm_req_out(req64), .dm_addr_out(dma64), .dm_ack_in(ack64), .dm_rdata_in(rdat64),
    .lu_valid_out(val64), .lu_data_out(dat64), .lu_rd_out(lrd64), .lu_fault_out(flt64)
  );

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are inspected 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset32(input string tag);
    chk({tag, ".ready"}, rdy32, 1);
    chk({tag, ".req"},   req32, 0);
    chk({tag, ".addr"},  dma32, 0);
    chk({tag, ".valid"}, val32, 0);
    chk({tag, ".data"},  dat32, 0);
    chk({tag, ".rd"},    lrd32, 0);
    chk({tag, ".fault"}, flt32, 0);
  endtask

  // Single-beat load on the 32-bit unit with a given number of wait cycles.
  task automatic load32(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [4:0] rd, input logic [31:0] mem,
                        input int waits, input logic [31:0] exp);
    logic [31:0] ea;
    ea = {a[31:2], 2'b00};
    v32 = 1'b1; a32 = a; sz32 = sz; un32 = u; rd32 = rd;
    step();
    // Garbage on the request port while busy must be ignored.
    a32 = 32'hDEAD_BEEF; rd32 = 5'd31; sz32 = 2'd0; un32 = ~u;
    for (int w = 0; w < waits; w++) begin
      chk({tag, ".wait_req"},   req32, 1);
      chk({tag, ".wait_addr"},  dma32, ea);
      chk({tag, ".wait_ready"}, rdy32, 0);
      step();
    end
    chk({tag, ".req"},  req32, 1);
    chk({tag, ".addr"}, dma32, ea);
    ack32 = 1'b1; rdat32 = mem;
    step();
    ack32 = 1'b0; v32 = 1'b0;
    chk({tag, ".valid"}, val32, 1);
    chk({tag, ".data"},  dat32, exp);
    chk({tag, ".rd"},    lrd32, rd);
    chk({tag, ".fault"}, flt32, 0);
    chk({tag, ".done_req"}, req32, 0);
    step();
    chk({tag, ".valid_end"}, val32, 0);
    chk({tag, ".ready_end"}, rdy32, 1);
    chk({tag, ".data_hold"}, dat32, exp);
  endtask

  // Request that must fault without touching memory.
  task automatic fault32(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [4:0] rd);
    v32 = 1'b1; a32 = a; sz32 = sz; un32 = u; rd32 = rd;
    step();
    v32 = 1'b0;
    chk({tag, ".valid"}, val32, 1);
    chk({tag, ".fault"}, flt32, 1);
    chk({tag, ".data"},  dat32, 0);
    chk({tag, ".rd"},    lrd32, rd);
    chk({tag, ".req"},   req32, 0);
    step();
    chk({tag, ".valid_end"}, val32, 0);
    chk({tag, ".req_end"},   req32, 0);
    chk({tag, ".ready_end"}, rdy32, 1);
    chk({tag, ".fault_hold"}, flt32, 1);
  endtask

  task automatic load64(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [4:0] rd, input logic [63:0] mem,
                        input logic [63:0] exp);
    v64 = 1'b1; a64 = a; sz64 = sz; un64 = u; rd64 = rd;
    step();
    v64 = 1'b0;
    chk({tag, ".req"},  req64, 1);
    chk({tag, ".addr"}, dma64, {a[31:3], 3'b000});
    ack64 = 1'b1; rdat64 = mem;
    step();
    ack64 = 1'b0;
    chk({tag, ".valid"}, val64, 1);
    chk({tag, ".data"},  dat64, exp);
    chk({tag, ".rd"},    lrd64, rd);
    chk({tag, ".fault"}, flt64, 0);
    step();
    chk({tag, ".valid_end"}, val64, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a pending request: reset must win.
    rst = 1'b1; v32 = 1'b1; a32 = 32'h0000_0040;
    step();
    step();
    chk_reset32("reset");
    chk("reset64.ready", rdy64, 1);
    chk("reset64.data",  dat64, 0);
    v32 = 1'b0;
    rst = 1'b0;
    step();
    chk("post_reset.req", req32, 0);

    load32("sbyte",       32'h0000_1003, 2'd0, 1'b0, 5'd5,  32'h80AA_BBCC, 0, 32'hFFFF_FF80);
    load32("uhalf",       32'h0000_2002, 2'd1, 1'b1, 5'd6,  32'h9123_4567, 0, 32'h0000_9123);
    load32("shalf",       32'h0000_2002, 2'd1, 1'b0, 5'd6,  32'h9123_4567, 0, 32'hFFFF_9123);
    load32("shalf_off1",  32'h0000_3001, 2'd1, 1'b0, 5'd8,  32'h11A2_B344, 0, 32'hFFFF_A2B3);
    load32("uword",       32'h0000_4000, 2'd2, 1'b1, 5'd9,  32'h8234_5678, 0, 32'h8234_5678);
    load32("wait_word",   32'hFFFF_FFFC, 2'd2, 1'b0, 5'd11, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);

`ifdef MISALIGNED_SPLIT_EN
    // Crossing signed word, zero-wait.
    v32 = 1'b1; a32 = 32'h0000_0FFE; sz32 = 2'd2; un32 = 1'b0; rd32 = 5'd7;
    step();
    v32 = 1'b0;
    chk("cross.b0_req",  req32, 1);
    chk("cross.b0_addr", dma32, 32'h0000_0FFC);
    ack32 = 1'b1; rdat32 = 32'hBEEF_0000;
    step();
    chk("cross.b1_req",   req32, 1);
    chk("cross.b1_addr",  dma32, 32'h0000_1000);
    chk("cross.b1_valid", val32, 0);
    rdat32 = 32'h0000_8765;
    step();
    ack32 = 1'b0;
    chk("cross.valid", val32, 1);
    chk("cross.data",  dat32, 32'h8765_BEEF);
    chk("cross.fault", flt32, 0);
    chk("cross.rd",    lrd32, 7);
    step();
    chk("cross.valid_end", val32, 0);
    chk("cross.ready_end", rdy32, 1);

    // Crossing word at the top of the address space with 3 waits per beat.
    v32 = 1'b1; a32 = 32'hFFFF_FFFE; sz32 = 2'd2; un32 = 1'b0; rd32 = 5'd12;
    step();
    v32 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("wrap.b0_req",   req32, 1);
      chk("wrap.b0_addr",  dma32, 32'hFFFF_FFFC);
      chk("wrap.b0_ready", rdy32, 0);
      step();
    end
    ack32 = 1'b1; rdat32 = 32'h5566_0000;
    chk("wrap.b0_addr_ack", dma32, 32'hFFFF_FFFC);
    step();
    ack32 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("wrap.b1_req",   req32, 1);
      chk("wrap.b1_addr",  dma32, 32'h0000_0000);
      chk("wrap.b1_ready", rdy32, 0);
      chk("wrap.b1_valid", val32, 0);
      step();
    end
    ack32 = 1'b1; rdat32 = 32'h0000_1234;
    step();
    ack32 = 1'b0;
    chk("wrap.valid", val32, 1);
    chk("wrap.ready", rdy32, 0);
    chk("wrap.data",  dat32, 32'h1234_5566);
    chk("wrap.rd",    lrd32, 12);
    step();
    chk("wrap.valid_end", val32, 0);

    // Reset during the second beat, then a stale ack.
    v32 = 1'b1; a32 = 32'h0000_0FFE; sz32 = 2'd2; un32 = 1'b0; rd32 = 5'd3;
    step();
    v32 = 1'b0;
    ack32 = 1'b1; rdat32 = 32'hBEEF_0000;
    step();
    ack32 = 1'b0;
    chk("rst_mid.in_beat1", dma32, 32'h0000_1000);
`else
    fault32("cross_nosplit", 32'h0000_0FFE, 2'd2, 1'b0, 5'd7);
    fault32("wrap_nosplit",  32'hFFFF_FFFE, 2'd2, 1'b0, 5'd12);

    // Reset while the only beat is waiting, then a stale ack.
    v32 = 1'b1; a32 = 32'h0000_0040; sz32 = 2'd2; un32 = 1'b0; rd32 = 5'd3;
    step();
    v32 = 1'b0;
    chk("rst_mid.in_beat0", req32, 1);
`endif
    rst = 1'b1;
    step();
    chk_reset32("rst_mid");
    rst = 1'b0; ack32 = 1'b1; rdat32 = 32'h1234_5678;
    step();
    ack32 = 1'b0;
    chk("rst_mid.no_valid", val32, 0);
    chk("rst_mid.no_req",   req32, 0);
    chk("rst_mid.ready",    rdy32, 1);
    step();
    chk("rst_mid.no_valid2", val32, 0);
    chk("rst_mid.data",      dat32, 0);

    fault32("illegal_dword", 32'h0000_0010, 2'd3, 1'b0, 5'd9);
    load32("after_fault",    32'h0000_5000, 2'd0, 1'b1, 5'd2, 32'h0000_00F0, 0, 32'h0000_00F0);

    load64("dword64", 32'h0000_0008, 2'd3, 1'b0, 5'd4, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    load64("sword64", 32'h0000_0014, 2'd2, 1'b0, 5'd5, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    load64("uword64", 32'h0000_0014, 2'd2, 1'b1, 5'd6, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
